zlave_regbank: RTL and testbench
================================

// Module: zlave_regbank
// PURPOSE
//  Parametrised Avalon-MM slave register bank; generation successor of the single-register slave template.
//  Provides NUM_REGS registers of DATA_WIDTH bits with per-byte write enables and a per-register readback mode.
//  Read latency is fixed at 2 cycles and is signalled by slave_readdatavalid.
//  Sits between the system interconnect and watch peripherals (display, time counters, buttons).
// PARAMETERS
//  DATA_WIDTH  32      register width in bits; multiple of 8, range 8..64
//  NUM_REGS    8       number of registers; range 1..2**ADDR_WIDTH
//  ADDR_WIDTH  4       slave word-address width
//  MODE_MASK   'h0     bit i=1: reg i reads back user_dataout; bit i=0: reads back sampled user_datain
// PORTS
//  clk                  in   1                    system clock, all logic on rising edge
//  reset                in   1                    synchronous, active-high reset
//  slave_address        in   ADDR_WIDTH           word address
//  slave_read           in   1                    read request, one cycle per transfer
//  slave_write          in   1                    write request, one cycle per transfer
//  slave_byteenable     in   DATA_WIDTH/8         byte lanes for writes
//  slave_writedata      in   DATA_WIDTH           write data
//  slave_readdata       out  DATA_WIDTH           registered read data
//  slave_readdatavalid  out  1                    1-cycle pulse qualifying slave_readdata
//  user_dataout         out  NUM_REGS*DATA_WIDTH  register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//  user_datain          in   NUM_REGS*DATA_WIDTH  peripheral inputs, same packing
//  user_chipselect      out  NUM_REGS             one-hot register select towards peripherals
//  user_write           out  1                    write strobe, slave_write delayed 1 cycle
//  user_read            out  1                    slave_read, combinational pass-through
//  user_byteenable      out  DATA_WIDTH/8         byte enables aligned with user_chipselect
// BEHAVIOUR
//  Reset (sync): all registers, user_dataout, slave_readdata, slave_readdatavalid, delayed strobes and pipeline stages = 0.
//   An in-flight read is dropped; no readdatavalid is produced for it.
//  Decode: hit[i] = (slave_address==i) & (slave_read|slave_write), for i < NUM_REGS.
//   Address >= NUM_REGS: write ignored; read completes normally with data 0.
//  Write, cycle N: at edge ending N, byte b of reg i loads writedata byte b iff hit[i] & slave_byteenable[b].
//   user_dataout reflects the write in cycle N+1. Bytes whose enable is 0 keep their value.
//  Read pipeline, request in cycle N:
//   stage 1, edge ending N: latch register index; sample user_datain[i] if MODE_MASK[i]==0.
//   stage 2, edge ending N+1: readdata <= (MODE_MASK[i] ? user_dataout[i] : sample).
//   In cycle N+2: slave_readdatavalid=1 with valid data; readdata holds until the next read completes.
//  Back-to-back reads are fully pipelined at one per cycle; there is no stall.
//  Read of an out-mode register in the cycle after a write to it returns the new value.
//  Simultaneous read and write in one cycle: the write is performed; the read is discarded (no valid).
//  User side:
//   - in the cycle after a write: user_write=1, user_chipselect=registered hit, user_byteenable=registered byteenable.
//   - otherwise: user_chipselect=current hit, user_byteenable=slave_byteenable, user_write=0.
//  Out-of-range write: user_write still pulses, with user_chipselect=0.
// TESTING
//  1. Reset, then read reg 0..NUM_REGS-1 -> readdata=0; readdatavalid exactly 2 cycles after each read.
//  2. MODE_MASK='h1; write reg0 'hDEADBEEF, be='b0101, over 0 -> user_dataout[0]='h00AD00EF; read back 'h00AD00EF.
//  3. Reg1 in-mode, user_datain[1]='h12345678; read at N, change datain to 'h0 at N+1 -> readdata='h12345678 at N+2.
//  4. Reads to 0,1,2 in consecutive cycles -> three consecutive valid pulses, data in request order; address 9 -> data 0.
//  5. Write reg2 'hA5 then read reg2 next cycle (out-mode) -> returns 'hA5; user_write=1, user_chipselect='b100 in cycle N+1.
//  6. Assert reset in the cycle after a read request -> no readdatavalid; all outputs 0 in the cycle after reset.

Source files
------------

// File: rtl/zlave_regbank.sv
// Avalon-MM register bank: NUM_REGS x DATA_WIDTH, byte-enabled writes, per-register readback source.
// Read latency fixed at 2 cycles via slave_readdatavalid; no backpressure, one request accepted per cycle.
module zlave_regbank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter int                  ADDR_WIDTH = 4,
  parameter logic [NUM_REGS-1:0] MODE_MASK  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          slave_address,
  input  logic                           slave_read,
  input  logic                           slave_write,
  input  logic [DATA_WIDTH/8-1:0]        slave_byteenable,
  input  logic [DATA_WIDTH-1:0]          slave_writedata,
  output logic [DATA_WIDTH-1:0]          slave_readdata,
  output logic                           slave_readdatavalid,
  output logic [NUM_REGS*DATA_WIDTH-1:0] user_dataout,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] user_datain,
  output logic [NUM_REGS-1:0]            user_chipselect,
  output logic                           user_write,
  output logic                           user_read,
  output logic [DATA_WIDTH/8-1:0]        user_byteenable
);
  localparam int NB = DATA_WIDTH / 8;

  logic [NUM_REGS-1:0]            hit;
  logic [NUM_REGS-1:0]            hit_q;
  logic [NUM_REGS-1:0]            rd_sel_q;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q;
  logic [DATA_WIDTH-1:0]          sample_d;
  logic [DATA_WIDTH-1:0]          sample_q;
  logic [DATA_WIDTH-1:0]          rd_mux;
  logic                           rd_go;
  logic                           rd_vld_q;
  logic                           wr_q;
  logic [NB-1:0]                  be_q;

  // A read coinciding with a write is dropped; the write wins.
  assign rd_go = slave_read & ~slave_write;

  always_comb begin
    hit      = '0;
    sample_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (slave_address == ADDR_WIDTH'(i)) && (slave_read || slave_write);
      if (hit[i] && !MODE_MASK[i])
        sample_d = user_datain[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Out-of-range reads leave rd_sel_q all-zero, so they return 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_q[i])
        rd_mux = MODE_MASK[i] ? regs_q[i*DATA_WIDTH +: DATA_WIDTH] : sample_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q              <= '0;
      rd_sel_q            <= '0;
      sample_q            <= '0;
      rd_vld_q            <= 1'b0;
      slave_readdata      <= '0;
      slave_readdatavalid <= 1'b0;
      wr_q                <= 1'b0;
      hit_q               <= '0;
      be_q                <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (slave_write && hit[i] && slave_byteenable[b])
            regs_q[i*DATA_WIDTH + 8*b +: 8] <= slave_writedata[8*b +: 8];
        end
      end
      rd_vld_q <= rd_go;
      if (rd_go) begin
        rd_sel_q <= hit;
        sample_q <= sample_d;
      end
      slave_readdatavalid <= rd_vld_q;
      if (rd_vld_q)
        slave_readdata <= rd_mux;
      wr_q  <= slave_write;
      hit_q <= hit;
      be_q  <= slave_byteenable;
    end
  end

  assign user_dataout    = regs_q;
  assign user_read       = slave_read;
  assign user_write      = wr_q;
  assign user_chipselect = wr_q ? hit_q : hit;
  assign user_byteenable = wr_q ? be_q : slave_byteenable;

endmodule

// File: tb/tb_zlave_regbank.sv
// Self-checking bench for zlave_regbank: directed scenarios then randomized traffic against a cycle-level model.
module tb_zlave_regbank;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 4;
  localparam int NB = DW / 8;
  localparam logic [NR-1:0] MASK = 8'hA5;

  logic             clk = 1'b0;
  logic             reset;
  logic [AW-1:0]    slave_address;
  logic             slave_read;
  logic             slave_write;
  logic [NB-1:0]    slave_byteenable;
  logic [DW-1:0]    slave_writedata;
  logic [DW-1:0]    slave_readdata;
  logic             slave_readdatavalid;
  logic [NR*DW-1:0] user_dataout;
  logic [NR*DW-1:0] user_datain;
  logic [NR-1:0]    user_chipselect;
  logic             user_write;
  logic             user_read;
  logic [NB-1:0]    user_byteenable;

  always #5 clk = ~clk;

  zlave_regbank #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .MODE_MASK(MASK)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .slave_address       (slave_address),
    .slave_read          (slave_read),
    .slave_write         (slave_write),
    .slave_byteenable    (slave_byteenable),
    .slave_writedata     (slave_writedata),
    .slave_readdata      (slave_readdata),
    .slave_readdatavalid (slave_readdatavalid),
    .user_dataout        (user_dataout),
    .user_datain         (user_datain),
    .user_chipselect     (user_chipselect),
    .user_write          (user_write),
    .user_read           (user_read),
    .user_byteenable     (user_byteenable)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc_n = 0;
  bit            do_chk = 1'b0;
  logic [DW-1:0] mdl [NR];
  logic [DW-1:0] din [NR];
  rd_t           pend [$];
  logic [DW-1:0] exp_rdata;
  logic          pw;
  logic [NR-1:0] pcs;
  logic [NB-1:0] pbe;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] pack_mdl();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = mdl[i];
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    pend.delete();
    exp_rdata = '0;
    pw  = 1'b0;
    pcs = '0;
    pbe = '0;
  endtask

  // One bus cycle: drive, check the DUT mid-cycle against the model, then advance the model.
  task automatic cyc(input logic rst, input logic rd, input logic wr, input int addr,
                     input logic [NB-1:0] be, input logic [DW-1:0] wd);
    logic [NR-1:0] h;
    logic          exp_v;
    logic [DW-1:0] v;
    reset            = rst;
    slave_read       = rd;
    slave_write      = wr;
    slave_address    = AW'(addr);
    slave_byteenable = be;
    slave_writedata  = wd;
    for (int i = 0; i < NR; i++) user_datain[i*DW +: DW] = din[i];
    h = '0;
    if (addr < NR && (rd || wr)) h[addr] = 1'b1;
    @(negedge clk);
    exp_v = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc_n) begin
      exp_v     = 1'b1;
      exp_rdata = pend[0].d;
      void'(pend.pop_front());
    end
    if (do_chk) begin
      check_val("readdatavalid",   256'(slave_readdatavalid), 256'(exp_v));
      check_val("readdata",        256'(slave_readdata),      256'(exp_rdata));
      check_val("user_dataout",    256'(user_dataout),        256'(pack_mdl()));
      check_val("user_write",      256'(user_write),          256'(pw));
      check_val("user_chipselect", 256'(user_chipselect),     256'(pw ? pcs : h));
      check_val("user_byteenable", 256'(user_byteenable),     256'(pw ? pbe : be));
      check_val("user_read",       256'(user_read),           256'(rd));
    end
    if (rst) begin
      clear_model();
    end else begin
      pw  = wr;
      pcs = h;
      pbe = be;
      if (wr && addr < NR)
        for (int b = 0; b < NB; b++)
          if (be[b]) mdl[addr][8*b +: 8] = wd[8*b +: 8];
      if (rd && !wr) begin
        v = (addr < NR) ? (MASK[addr] ? mdl[addr] : din[addr]) : '0;
        pend.push_back('{cyc_n + 2, v});
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) din[i] = '0;
    clear_model();
    // First reset cycle leaves the DUT undefined until its edge, so it goes unchecked.
    cyc(1'b1, 1'b0, 1'b0, 0, '0, '0);
    do_chk = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 0, '0, '0);
    idle(1);

    // Reads of every register straight out of reset.
    for (int r = 0; r < NR; r++) cyc(1'b0, 1'b1, 1'b0, r, '0, '0);
    idle(3);

    // Partial byte write to reg0 (out-mode), then read back.
    cyc(1'b0, 1'b0, 1'b1, 0, 4'b0101, 32'hDEADBEEF);
    check_val("t2_dataout0", 256'(user_dataout[31:0]), 256'(32'h00AD00EF));
    cyc(1'b0, 1'b1, 1'b0, 0, '0, '0);
    idle(3);

    // In-mode sampling: datain changes right after the request.
    din[1] = 32'h12345678;
    cyc(1'b0, 1'b1, 1'b0, 1, '0, '0);
    din[1] = 32'h0;
    idle(1);
    check_val("t3_rdata", 256'(slave_readdata), 256'(32'h12345678));
    idle(2);

    // Back-to-back reads including an out-of-range address.
    din[0] = 32'hAAAA0000; din[1] = 32'h11111111; din[2] = 32'h22222222;
    cyc(1'b0, 1'b1, 1'b0, 0, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, 2, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, 9, '0, '0);
    idle(3);

    // Write then immediate read of an out-mode register; out-of-range write.
    cyc(1'b0, 1'b0, 1'b1, 2, 4'hF, 32'h000000A5);
    check_val("t5_cs", 256'(user_chipselect), 256'(8'b0000_0100));
    cyc(1'b0, 1'b1, 1'b0, 2, '0, '0);
    cyc(1'b0, 1'b0, 1'b1, 12, 4'hF, 32'hFFFFFFFF);
    cyc(1'b0, 1'b1, 1'b1, 5, 4'hF, 32'h55AA55AA);
    idle(3);

    // Reset one cycle after a read request drops it.
    cyc(1'b0, 1'b1, 1'b0, 5, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, 0, '0, '0);
    idle(3);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      logic rs, rd, wr;
      if ($urandom_range(0, 3) == 0) din[$urandom_range(0, NR-1)] = $urandom;
      rs = ($urandom_range(0, 60) == 0);
      rd = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 2) == 0);
      cyc(rs, rd, wr, int'($urandom_range(0, 11)), NB'($urandom), $urandom);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
